// File: rtl/bsg_astar_path_output_channel.sv
// Streams a finished A* path to the host as header, packed point words and an optional
// checksum trailer (enabled by defining BSG_ASTAR_PATH_CHECKSUM_EN).
module bsg_astar_path_output_channel #(
    parameter int board_width_p  = 16,
    parameter int max_path_len_p = 64,
    localparam int len_width_lp  = (max_path_len_p + 1 > 1) ? $clog2(max_path_len_p + 1) : 1,
    localparam int addr_width_lp = (max_path_len_p > 1) ? $clog2(max_path_len_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic                     found_i,
    input  logic [len_width_lp-1:0]  path_len_i,
    output logic                     ready_o,
    output logic                     rd_v_o,
    output logic [addr_width_lp-1:0] rd_addr_o,
    input  logic [11:0]              rd_data_i,
    output logic [63:0]              data_o,
    output logic                     v_o,
    input  logic                     yumi_i
);

    if (board_width_p > 64 || max_path_len_p > 255 || max_path_len_p < 1) begin : g_bad_cfg
        $error("bsg_astar_path_output_channel: unsupported board_width_p/max_path_len_p");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_FETCH, S_SEND
`ifdef BSG_ASTAR_PATH_CHECKSUM_EN
        , S_TRL
`endif
    } state_e;

    localparam logic [len_width_lp-1:0] max_len_lp = len_width_lp'(max_path_len_p);

    state_e                   state_q, state_d;
    logic [len_width_lp-1:0]  len_q, len_d;
    logic [len_width_lp-1:0]  ptr_q, ptr_d;       // next point index to read
    logic [2:0]               rd_cnt_q, rd_cnt_d;   // reads issued for the current word
    logic [2:0]               cap_cnt_q, cap_cnt_d; // points captured for the current word
    logic [2:0]               word_n_q, word_n_d;
    logic                     cap_v_q, cap_v_d;
    logic                     rd_v_q, rd_v_d;
    logic [addr_width_lp-1:0] rd_addr_q, rd_addr_d;
    logic [59:0]              slots_q, slots_d;
    logic [63:0]              data_q, data_d;
    logic                     v_q, v_d;
`ifdef BSG_ASTAR_PATH_CHECKSUM_EN
    logic [63:0]              csum_q, csum_d;
`endif

    logic [len_width_lp-1:0]  len_new, rem;
    logic                     ovf_new;
    logic [2:0]               next_n;

    assign ovf_new = found_i & (path_len_i > max_len_lp);
    assign len_new = !found_i ? '0 : (ovf_new ? max_len_lp : path_len_i);
    assign rem     = len_q - ptr_q;
    assign next_n  = (rem > len_width_lp'(5)) ? 3'd5 : 3'(rem);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        ptr_d     = ptr_q;
        rd_cnt_d  = rd_cnt_q;
        cap_cnt_d = cap_cnt_q;
        word_n_d  = word_n_q;
        cap_v_d   = 1'b0;
        rd_v_d    = 1'b0;
        rd_addr_d = rd_addr_q;
        slots_d   = slots_q;
        data_d    = data_q;
        v_d       = v_q;
`ifdef BSG_ASTAR_PATH_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (v_i) begin
                    state_d = S_HDR;
                    len_d   = len_new;
                    ptr_d   = '0;
                    data_d  = {8'hA5, 8'(len_new), found_i, ovf_new, 46'b0};
                    v_d     = 1'b1;
`ifdef BSG_ASTAR_PATH_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_HDR, S_SEND: begin
                if (yumi_i) begin
`ifdef BSG_ASTAR_PATH_CHECKSUM_EN
                    csum_d = csum_q ^ data_q;
`endif
                    if (ptr_q < len_q) begin
                        // first read of the next word goes out together with the state change
                        state_d   = S_FETCH;
                        v_d       = 1'b0;
                        rd_v_d    = 1'b1;
                        rd_addr_d = ptr_q[addr_width_lp-1:0];
                        ptr_d     = ptr_q + len_width_lp'(1);
                        rd_cnt_d  = 3'd1;
                        cap_cnt_d = 3'd0;
                        word_n_d  = next_n;
                        slots_d   = '0;
                    end else begin
`ifdef BSG_ASTAR_PATH_CHECKSUM_EN
                        state_d = S_TRL;
                        data_d  = csum_q ^ data_q;
`else
                        state_d = S_IDLE;
                        v_d     = 1'b0;
`endif
                    end
                end
            end
            S_FETCH: begin
                if (rd_v_q && rd_cnt_q != word_n_q) begin
                    rd_v_d    = 1'b1;
                    rd_addr_d = ptr_q[addr_width_lp-1:0];
                    ptr_d     = ptr_q + len_width_lp'(1);
                    rd_cnt_d  = rd_cnt_q + 3'd1;
                end
                cap_v_d = rd_v_q;
                if (cap_v_q) begin
                    for (int k = 0; k < 5; k++) begin
                        if (cap_cnt_q == 3'(k)) slots_d[k*12 +: 12] = rd_data_i;
                    end
                    cap_cnt_d = cap_cnt_q + 3'd1;
                    if (cap_cnt_q + 3'd1 == word_n_q) begin
                        state_d = S_SEND;
                        v_d     = 1'b1;
                        data_d  = {1'b0, word_n_q, slots_d};
                    end
                end
            end
`ifdef BSG_ASTAR_PATH_CHECKSUM_EN
            S_TRL: begin
                if (yumi_i) begin
                    state_d = S_IDLE;
                    v_d     = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            ptr_q     <= '0;
            rd_cnt_q  <= '0;
            cap_cnt_q <= '0;
            word_n_q  <= '0;
            cap_v_q   <= 1'b0;
            rd_v_q    <= 1'b0;
            rd_addr_q <= '0;
            slots_q   <= '0;
            data_q    <= '0;
            v_q       <= 1'b0;
`ifdef BSG_ASTAR_PATH_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            ptr_q     <= ptr_d;
            rd_cnt_q  <= rd_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            word_n_q  <= word_n_d;
            cap_v_q   <= cap_v_d;
            rd_v_q    <= rd_v_d;
            rd_addr_q <= rd_addr_d;
            slots_q   <= slots_d;
            data_q    <= data_d;
            v_q       <= v_d;
`ifdef BSG_ASTAR_PATH_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign ready_o   = (state_q == S_IDLE);
    assign rd_v_o    = rd_v_q;
    assign rd_addr_o = rd_addr_q;
    assign data_o    = data_q;
    assign v_o       = v_q;

endmodule

// File: tb/tb_bsg_astar_path_output_channel.sv
// Directed bench for bsg_astar_path_output_channel: a path-memory model answers reads,
// a reference model queues the expected words, and a consumer pops and compares them.
module tb_bsg_astar_path_output_channel;
    localparam int MAXL = 64;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        v_i, found_i, yumi_i;
    logic [6:0]  path_len_i;
    logic        ready_o, rd_v_o, v_o;
    logic [5:0]  rd_addr_o;
    logic [11:0] rd_data_i;
    logic [63:0] data_o;

    always #5 clk = ~clk;

    bsg_astar_path_output_channel #(.board_width_p(16), .max_path_len_p(MAXL)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .found_i(found_i),
        .path_len_i(path_len_i), .ready_o(ready_o), .rd_v_o(rd_v_o), .rd_addr_o(rd_addr_o),
        .rd_data_i(rd_data_i), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i)
    );

    // synchronous path memory: data appears the cycle after the read strobe
    logic [11:0] mem [MAXL];
    always @(posedge clk) if (rd_v_o) rd_data_i <= mem[rd_addr_o];

    logic [63:0] exp_q[$];
    int          lat_q[$];
    int          pass_cnt = 0, total_cnt = 0;
    int          rd_pulses = 0, addr_viol = 0;
    int          cur_len = 0, rd_base = 0, viol_base = 0;

    always @(negedge clk) begin
        if (rd_v_o === 1'b1) begin
            rd_pulses++;
            if (int'(rd_addr_o) >= cur_len) addr_viol++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // reference model: header, packed point words, optional checksum trailer
    task automatic push_path(input bit found, input int len_in);
        int          len, p, n;
        bit          ovf;
        logic [63:0] w, cs;
        ovf = found && (len_in > MAXL);
        len = !found ? 0 : (ovf ? MAXL : len_in);
        w = {8'hA5, 8'(len), found, ovf, 46'b0};
        exp_q.push_back(w);
        lat_q.push_back(-1);
        cs = w;
        p = 0;
        while (p < len) begin
            n = (len - p > 5) ? 5 : len - p;
            w = '0;
            w[63:60] = 4'(n);
            for (int k = 0; k < n; k++) w[12*k +: 12] = mem[p+k];
            exp_q.push_back(w);
            lat_q.push_back(n + 1);
            cs ^= w;
            p += n;
        end
`ifdef BSG_ASTAR_PATH_CHECKSUM_EN
        exp_q.push_back(cs);
        lat_q.push_back(0);
`endif
        cur_len = len;
    endtask

    task automatic start_path(input bit found, input int len);
        int guard = 0;
        while (ready_o !== 1'b1 && guard < 300) begin @(negedge clk); guard++; end
        check("ready_before_accept", 64'(ready_o), 64'd1);
        push_path(found, len);
        rd_base   = rd_pulses;
        viol_base = addr_viol;
        v_i = 1'b1; found_i = found; path_len_i = 7'(len);
        @(negedge clk);
        v_i = 1'b0;
        check("hdr_v_next_cycle", 64'(v_o), 64'd1);
    endtask

    task automatic drain(input int nwords, input int stall, input bit chk_lat);
        for (int i = 0; i < nwords; i++) begin
            int          waited, exp_lat;
            logic [63:0] e, held;
            bit          stable;
            waited = 0;
            while (v_o !== 1'b1 && waited < 300) begin @(negedge clk); waited++; end
            e = exp_q.pop_front();
            exp_lat = lat_q.pop_front();
            check("word_v", 64'(v_o), 64'd1);
            check("word_data", data_o, e);
            if (chk_lat && exp_lat >= 0) check("word_latency", 64'(waited), 64'(exp_lat));
            if (stall > 0) begin
                held = data_o;
                stable = 1'b1;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    if (data_o !== held || v_o !== 1'b1 || rd_v_o !== 1'b0) stable = 1'b0;
                end
                check("stall_stable", 64'(stable), 64'd1);
            end
            yumi_i = 1'b1;
            @(negedge clk);
            yumi_i = 1'b0;
        end
    endtask

    task automatic path_done();
        check("all_words_seen", 64'(exp_q.size()), 64'd0);
        check("ready_after_last", 64'(ready_o), 64'd1);
        check("read_count", 64'(rd_pulses - rd_base), 64'(cur_len));
        check("addr_in_range", 64'(addr_viol - viol_base), 64'd0);
    endtask

    initial begin
        bit idle_ok;
        reset_n_i = 1'b0; v_i = 1'b0; found_i = 1'b0; path_len_i = '0; yumi_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_v", 64'(v_o), 64'd0);
        check("rst_rd_v", 64'(rd_v_o), 64'd0);
        check("rst_data", data_o, 64'd0);
        check("rst_addr", 64'(rd_addr_o), 64'd0);
        reset_n_i = 1'b1;
        @(negedge clk);

        // a stray yumi while nothing is offered must do nothing
        yumi_i = 1'b1;
        @(negedge clk);
        yumi_i = 1'b0;
        check("idle_yumi_v", 64'(v_o), 64'd0);
        check("idle_yumi_ready", 64'(ready_o), 64'd1);

        // found path of 7 points (i, 2i)
        for (int i = 0; i < MAXL; i++) mem[i] = {6'(i), 6'(2*i)};
        start_path(1'b1, 7);
        check("len7_header", data_o, 64'hA507_8000_0000_0000);
        drain(exp_q.size(), 0, 1'b1);
        path_done();

        // no path: header only, no reads
        start_path(1'b0, 20);
        check("notfound_header", data_o, 64'hA500_0000_0000_0000);
        drain(exp_q.size(), 0, 1'b1);
        path_done();

        // over-long path, clamped to max_path_len_p (127 is the widest encodable length)
        for (int i = 0; i < MAXL; i++) mem[i] = 12'($urandom_range(0, 4095));
        start_path(1'b1, 127);
        check("ovf_header", data_o, 64'hA540_C000_0000_0000);
        drain(exp_q.size(), 0, 1'b1);
        path_done();

        // consumer stalls 10 cycles on every word
        for (int i = 0; i < MAXL; i++) mem[i] = 12'($urandom_range(0, 4095));
        start_path(1'b1, 8);
        drain(exp_q.size(), 10, 1'b1);
        path_done();

        // reset during FETCH of word 2, then a fresh 5-point path
        for (int i = 0; i < MAXL; i++) mem[i] = {6'(i), 6'(2*i)};
        start_path(1'b1, 7);
        drain(2, 0, 1'b1);
        #2 reset_n_i = 1'b0;
        #1;
        check("midrst_ready", 64'(ready_o), 64'd1);
        check("midrst_v", 64'(v_o), 64'd0);
        check("midrst_rd_v", 64'(rd_v_o), 64'd0);
        check("midrst_data", data_o, 64'd0);
        check("midrst_addr", 64'(rd_addr_o), 64'd0);
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < MAXL; i++) mem[i] = 12'($urandom_range(0, 4095));
        start_path(1'b1, 5);
        drain(exp_q.size(), 0, 1'b1);
        path_done();

        // back-to-back: next result offered the cycle ready_o rises
        start_path(1'b1, 3);
        drain(exp_q.size(), 0, 1'b1);
        path_done();
        start_path(1'b1, 6);
        drain(exp_q.size(), 0, 1'b1);
        path_done();

        // a result offered while busy is dropped until re-presented
        start_path(1'b1, 4);
        drain(1, 0, 1'b1);
        for (int g = 0; g < 300 && v_o !== 1'b1; g++) @(negedge clk);
        v_i = 1'b1; found_i = 1'b1; path_len_i = 7'd9;
        @(negedge clk);
        v_i = 1'b0;
        drain(exp_q.size(), 0, 1'b0);
        path_done();
        idle_ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (v_o !== 1'b0 || ready_o !== 1'b1) idle_ok = 1'b0;
        end
        check("busy_vi_dropped", 64'(idle_ok), 64'd1);
        start_path(1'b1, 9);
        drain(exp_q.size(), 0, 1'b1);
        path_done();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
